// File: rtl/mem_arbiter.sv
// N-master to 1-slave memory arbiter with one outstanding transaction, fixed-priority or
// round-robin grant, and an optional response timeout reported through m_resp_err.
module mem_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ARB_MODE    = 0,
  parameter int TIMEOUT     = 0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_MASTERS-1:0]                m_req_valid,
  output logic [NUM_MASTERS-1:0]                m_req_ready,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_req_addr,
  input  logic [NUM_MASTERS-1:0]                m_req_wen,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_req_wdata,
  input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] m_req_wmask,
  output logic [NUM_MASTERS-1:0]                m_resp_valid,
  output logic [DATA_WIDTH-1:0]                 m_resp_rdata,
  output logic                                  m_resp_err,
  output logic                                  mem_req_valid,
  input  logic                                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0]                 mem_req_addr,
  output logic                                  mem_req_wen,
  output logic [DATA_WIDTH-1:0]                 mem_req_wdata,
  output logic [DATA_WIDTH/8-1:0]               mem_req_wmask,
  input  logic                                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]                 mem_resp_rdata
);
  localparam int MW = DATA_WIDTH / 8;
  localparam int IW = $clog2(NUM_MASTERS);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           owner_q, owner_d, rrPtr_q, rrPtr_d, grantIdx;
  logic                    grantFound;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    wen_q, wen_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [MW-1:0]           wmask_q, wmask_d;
  logic [NUM_MASTERS-1:0]  respValid_q, respValid_d, ownerHot;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [CW-1:0]           cnt_q, cnt_d, cntInc;
  logic                    expired;

  // Search wraps modulo NUM_MASTERS; in fixed-priority mode it always starts at index 0.
  always_comb begin : grantSearch
    logic [IW:0] cand;
    grantFound = 1'b0;
    grantIdx   = '0;
    cand       = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      cand = (ARB_MODE == 1) ? ({1'b0, rrPtr_q} + (IW+1)'(k)) : (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_MASTERS)) cand = cand - (IW+1)'(NUM_MASTERS);
      if (!grantFound && m_req_valid[cand[IW-1:0]]) begin
        grantFound = 1'b1;
        grantIdx   = cand[IW-1:0];
      end
    end
  end

  assign ownerHot = NUM_MASTERS'(1) << owner_q;
  assign cntInc   = (TIMEOUT > 0) ? cnt_q + 1'b1 : '0;
  assign expired  = (TIMEOUT > 0) && (cnt_q == CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0));

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rrPtr_d     = rrPtr_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    respValid_d = '0;
    rdata_d     = rdata_q;
    err_d       = 1'b0;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (grantFound) begin
          owner_d = grantIdx;
          addr_d  = m_req_addr[grantIdx*ADDR_WIDTH +: ADDR_WIDTH];
          wen_d   = m_req_wen[grantIdx];
          wdata_d = m_req_wdata[grantIdx*DATA_WIDTH +: DATA_WIDTH];
          wmask_d = m_req_wmask[grantIdx*MW +: MW];
          if (ARB_MODE == 1)
            rrPtr_d = (grantIdx == IW'(NUM_MASTERS - 1)) ? '0 : grantIdx + 1'b1;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (expired) begin
          respValid_d = ownerHot;
          rdata_d     = '0;
          err_d       = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cntInc;
          if (mem_req_ready) state_d = WAIT;
        end
      end
      WAIT: begin
        // A response in the expiry cycle still counts as a normal completion.
        if (mem_resp_valid) begin
          respValid_d = ownerHot;
          rdata_d     = wen_q ? '0 : mem_resp_rdata;
          state_d     = IDLE;
        end else if (expired) begin
          respValid_d = ownerHot;
          rdata_d     = '0;
          err_d       = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cntInc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rrPtr_q     <= '0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      respValid_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rrPtr_q     <= rrPtr_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      respValid_q <= respValid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  // Ready is combinational from the request vector, so it is also masked while reset is held.
  assign m_req_ready   = (state_q == IDLE && grantFound && !rst) ? (NUM_MASTERS'(1) << grantIdx) : '0;
  assign mem_req_valid = (state_q == ISSUE);
  assign mem_req_addr  = addr_q;
  assign mem_req_wen   = wen_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wmask = wmask_q;
  assign m_resp_valid  = respValid_q;
  assign m_resp_rdata  = rdata_q;
  assign m_resp_err    = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a 2-master fixed-priority instance and a 3-master
// round-robin instance with TIMEOUT=5, checked by per-instance response scoreboards.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;
  localparam int NA = 2;
  localparam int NB = 3;

  typedef struct {
    int          master;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rstA, rstB;
  logic [NA-1:0]    aReqValid, aReqReady, aReqWen, aRespValid;
  logic [NA*AW-1:0] aReqAddr;
  logic [NA*DW-1:0] aReqWdata;
  logic [NA*MW-1:0] aReqWmask;
  logic [DW-1:0]    aRespRdata, aMemReqWdata, aMemRespRdata;
  logic             aRespErr, aMemReqValid, aMemReqReady, aMemReqWen, aMemRespValid;
  logic [AW-1:0]    aMemReqAddr;
  logic [MW-1:0]    aMemReqWmask;

  logic [NB-1:0]    bReqValid, bReqReady, bReqWen, bRespValid;
  logic [NB*AW-1:0] bReqAddr;
  logic [NB*DW-1:0] bReqWdata;
  logic [NB*MW-1:0] bReqWmask;
  logic [DW-1:0]    bRespRdata, bMemReqWdata, bMemRespRdata;
  logic             bRespErr, bMemReqValid, bMemReqReady, bMemReqWen, bMemRespValid;
  logic [AW-1:0]    bMemReqAddr;
  logic [MW-1:0]    bMemReqWmask;

  exp_t qA[$];
  exp_t qB[$];
  int   vecCount  = 0;
  int   missCount = 0;

  mem_arbiter #(.NUM_MASTERS(NA), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(0), .TIMEOUT(0)) dutA (
    .clk(clk), .rst(rstA),
    .m_req_valid(aReqValid), .m_req_ready(aReqReady), .m_req_addr(aReqAddr),
    .m_req_wen(aReqWen), .m_req_wdata(aReqWdata), .m_req_wmask(aReqWmask),
    .m_resp_valid(aRespValid), .m_resp_rdata(aRespRdata), .m_resp_err(aRespErr),
    .mem_req_valid(aMemReqValid), .mem_req_ready(aMemReqReady), .mem_req_addr(aMemReqAddr),
    .mem_req_wen(aMemReqWen), .mem_req_wdata(aMemReqWdata), .mem_req_wmask(aMemReqWmask),
    .mem_resp_valid(aMemRespValid), .mem_resp_rdata(aMemRespRdata)
  );

  mem_arbiter #(.NUM_MASTERS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(1), .TIMEOUT(5)) dutB (
    .clk(clk), .rst(rstB),
    .m_req_valid(bReqValid), .m_req_ready(bReqReady), .m_req_addr(bReqAddr),
    .m_req_wen(bReqWen), .m_req_wdata(bReqWdata), .m_req_wmask(bReqWmask),
    .m_resp_valid(bRespValid), .m_resp_rdata(bRespRdata), .m_resp_err(bRespErr),
    .mem_req_valid(bMemReqValid), .mem_req_ready(bMemReqReady), .mem_req_addr(bMemReqAddr),
    .mem_req_wen(bMemReqWen), .mem_req_wdata(bMemReqWdata), .mem_req_wmask(bMemReqWmask),
    .mem_resp_valid(bMemRespValid), .mem_resp_rdata(bMemRespRdata)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitMemA();
    bit ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (aMemReqValid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checkOutput("A grant within bound", 64'(ok), 64'd1);
  endtask

  task automatic waitMemB();
    bit ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bMemReqValid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checkOutput("B grant within bound", 64'(ok), 64'd1);
  endtask

  // Response monitors: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitorA
    exp_t e;
    if (aRespValid != '0) begin
      if (qA.size() == 0) begin
        checkOutput("A unexpected resp", 64'(aRespValid), 64'd0);
      end else begin
        e = qA.pop_front();
        checkOutput("A resp owner", 64'(aRespValid), 64'd1 << e.master);
        checkOutput("A resp rdata", 64'(aRespRdata), 64'(e.rdata));
        checkOutput("A resp err", 64'(aRespErr), 64'(e.err));
      end
    end
  end

  always @(negedge clk) begin : monitorB
    exp_t e;
    if (bRespValid != '0) begin
      if (qB.size() == 0) begin
        checkOutput("B unexpected resp", 64'(bRespValid), 64'd0);
      end else begin
        e = qB.pop_front();
        checkOutput("B resp owner", 64'(bRespValid), 64'd1 << e.master);
        checkOutput("B resp rdata", 64'(bRespRdata), 64'(e.rdata));
        checkOutput("B resp err", 64'(bRespErr), 64'(e.err));
      end
    end
  end

  task automatic applyStimulus();
    int order[4];
    order = '{0, 1, 2, 0};

    // Reset with requests pending: every output must stay low.
    rstA = 1'b1; rstB = 1'b1;
    aReqValid = 2'b11; aReqAddr = '0; aReqWen = '0; aReqWdata = '0; aReqWmask = '0;
    aMemReqReady = 1'b0; aMemRespValid = 1'b0; aMemRespRdata = '0;
    bReqValid = '0; bReqAddr = '0; bReqWen = '0; bReqWdata = '0; bReqWmask = '0;
    bMemReqReady = 1'b0; bMemRespValid = 1'b0; bMemRespRdata = '0;
    #1;
    checkOutput("A reset ready", 64'(aReqReady), 64'd0);
    checkOutput("A reset resp_valid", 64'(aRespValid), 64'd0);
    checkOutput("A reset mem_req_valid", 64'(aMemReqValid), 64'd0);
    checkOutput("A reset rdata", 64'(aRespRdata), 64'd0);
    tick(); tick();
    aReqValid = '0;
    rstA = 1'b0; rstB = 1'b0;

    // Single read from master1, memory ready at once, response one cycle later.
    tick();
    aReqValid = 2'b10; aReqAddr[63:32] = 32'h8000_0010; aReqWen = 2'b00;
    #1 checkOutput("A read ready", 64'(aReqReady), 64'h2);
    tick();
    aReqValid = '0;
    checkOutput("A read mem_req_valid T+1", 64'(aMemReqValid), 64'd1);
    checkOutput("A read mem_req_addr", 64'(aMemReqAddr), 64'h8000_0010);
    checkOutput("A read mem_req_wen", 64'(aMemReqWen), 64'd0);
    qA.push_back('{1, 32'hDEAD_BEEF, 1'b0});
    aMemReqReady = 1'b1;
    tick();
    aMemReqReady = 1'b0;
    checkOutput("A read wait drops valid", 64'(aMemReqValid), 64'd0);
    aMemRespValid = 1'b1; aMemRespRdata = 32'hDEAD_BEEF;
    tick();
    aMemRespValid = 1'b0;
    checkOutput("A read pulse at T+3", 64'(aRespValid), 64'h2);

    // Write from master0 with three cycles of backpressure; fields must stay latched.
    tick();
    aReqValid = 2'b01; aReqAddr[31:0] = 32'h8000_0004; aReqWen = 2'b01;
    aReqWdata[31:0] = 32'h1234_5678; aReqWmask[3:0] = 4'b0011;
    #1 checkOutput("A write ready", 64'(aReqReady), 64'h1);
    tick();
    aReqValid = '0; aReqAddr[31:0] = 32'hFFFF_FFFF; aReqWen = '0;
    aReqWdata[31:0] = '0; aReqWmask[3:0] = 4'hF;
    qA.push_back('{0, 32'h0, 1'b0});
    for (int c = 0; c < 4; c++) begin
      checkOutput("A write valid held", 64'(aMemReqValid), 64'd1);
      checkOutput("A write addr stable", 64'(aMemReqAddr), 64'h8000_0004);
      checkOutput("A write wen stable", 64'(aMemReqWen), 64'd1);
      checkOutput("A write wdata stable", 64'(aMemReqWdata), 64'h1234_5678);
      checkOutput("A write wmask stable", 64'(aMemReqWmask), 64'h3);
      aMemRespValid = (c == 0);
      aMemRespRdata = 32'h5A5A_5A5A;
      aMemReqReady  = (c == 3);
      tick();
    end
    aMemReqReady = 1'b0;
    aMemRespValid = 1'b1; aMemRespRdata = 32'hCAFE_F00D;
    tick();
    aMemRespValid = 1'b0;
    checkOutput("A write pulse", 64'(aRespValid), 64'h1);
    checkOutput("A write rdata zero", 64'(aRespRdata), 64'd0);

    // Fixed priority: both masters request continuously, master0 must win every time.
    tick();
    aReqAddr = {32'h0000_0200, 32'h0000_0100}; aReqWen = '0; aReqValid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      qA.push_back('{0, 32'hA000_0000 + 32'(k), 1'b0});
      waitMemA();
      checkOutput("A fixed winner addr", 64'(aMemReqAddr), 64'h100);
      checkOutput("A ready low outside idle", 64'(aReqReady), 64'd0);
      aMemReqReady = 1'b1;
      tick();
      aMemReqReady = 1'b0;
      aMemRespValid = 1'b1; aMemRespRdata = 32'hA000_0000 + 32'(k);
      tick();
      aMemRespValid = 1'b0;
    end
    aReqValid = '0;

    // Round-robin over three masters: order 0,1,2 then wrap to 0.
    bReqAddr = {32'h0000_1020, 32'h0000_1010, 32'h0000_1000}; bReqWen = '0; bReqValid = 3'b111;
    for (int k = 0; k < 4; k++) begin
      qB.push_back('{order[k], 32'hB000_0000 + 32'(k), 1'b0});
      waitMemB();
      checkOutput("B rr winner addr", 64'(bMemReqAddr), 64'h1000 + 64'(order[k] * 16));
      bMemReqReady = 1'b1;
      tick();
      bMemReqReady = 1'b0;
      bMemRespValid = 1'b1; bMemRespRdata = 32'hB000_0000 + 32'(k);
      tick();
      bMemRespValid = 1'b0;
    end
    bReqValid = '0;

    // Timeout: master2 granted, memory accepts but never answers.
    tick();
    bReqValid = 3'b100;
    #1 checkOutput("B timeout ready", 64'(bReqReady), 64'h4);
    tick();
    bReqValid = '0;
    qB.push_back('{2, 32'h0, 1'b1});
    checkOutput("B timeout issue", 64'(bMemReqValid), 64'd1);
    bMemReqReady = 1'b1;
    tick();
    bMemReqReady = 1'b0;
    for (int c = 1; c < 5; c++) begin
      checkOutput("B no early timeout", 64'(bRespValid), 64'd0);
      tick();
    end
    checkOutput("B timeout pulse", 64'(bRespValid), 64'h4);
    checkOutput("B timeout err", 64'(bRespErr), 64'd1);
    checkOutput("B timeout rdata", 64'(bRespRdata), 64'd0);
    tick(); tick();
    bMemRespValid = 1'b1; bMemRespRdata = 32'h5555_5555;
    tick();
    bMemRespValid = 1'b0;
    checkOutput("B late resp ignored", 64'(bRespValid), 64'd0);

    // Reset during WAIT with rr pointer advanced to 2 by a master1 grant.
    tick();
    bReqValid = 3'b010;
    #1 checkOutput("B pre-reset ready", 64'(bReqReady), 64'h2);
    tick();
    bReqValid = '0;
    bMemReqReady = 1'b1;
    tick();
    bMemReqReady = 1'b0;
    #3 rstB = 1'b1;
    bMemRespValid = 1'b1; bMemRespRdata = 32'h7777_7777;
    #1;
    checkOutput("B async reset mem_req_valid", 64'(bMemReqValid), 64'd0);
    checkOutput("B async reset mem_req_addr", 64'(bMemReqAddr), 64'd0);
    checkOutput("B async reset resp_valid", 64'(bRespValid), 64'd0);
    checkOutput("B async reset err", 64'(bRespErr), 64'd0);
    tick();
    #2 rstB = 1'b0;
    tick();
    bMemRespValid = 1'b0;
    tick();
    checkOutput("B no pulse after reset", 64'(bRespValid), 64'd0);
    bReqValid = 3'b110;
    #1 checkOutput("B rr restarts at 0", 64'(bReqReady), 64'h2);
    qB.push_back('{1, 32'hD00D_FEED, 1'b0});
    tick();
    bReqValid = '0;
    checkOutput("B fresh grant addr", 64'(bMemReqAddr), 64'h1010);
    bMemReqReady = 1'b1;
    tick();
    bMemReqReady = 1'b0;
    bMemRespValid = 1'b1; bMemRespRdata = 32'hD00D_FEED;
    tick();
    bMemRespValid = 1'b0;
    checkOutput("B fresh pulse", 64'(bRespValid), 64'h2);

    tick(); tick(); tick();
    checkOutput("A responses outstanding", 64'(qA.size()), 64'd0);
    checkOutput("B responses outstanding", 64'(qB.size()), 64'd0);
  endtask

  initial begin
    applyStimulus();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
